// File: rtl/led_sequencer.sv
// LED pattern sequencer: programmable step timer driving rotate, ping-pong and blink patterns.
// The step timer counts down to zero; the pattern engine advances on each terminal count.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_BLANK | after reset, all LEDs off until the first step
// S_UP    | rotate-up, one-hot at pos, pos increments
// S_DOWN  | rotate-down, one-hot at pos, pos decrements
// S_PING  | ping-pong, one-hot at pos, pos moves in dir, reverses at ends
// S_BLINK | blink-all, all LEDs follow phase
module led_sequencer #(
  parameter int          N_LED       = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             period_ld,
  input  logic [CNT_W-1:0] period_in,
  output logic [N_LED-1:0] led,
  output logic             step_pulse,
  output logic             wrap
);

  localparam int               POS_W    = $clog2(N_LED);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [N_LED-1:0] LED_OFF  = {N_LED{ACTIVE_LOW}};

  typedef enum logic [2:0] {
    S_BLANK = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_PING  = 3'd3,
    S_BLINK = 3'd4
  } state_t;

  state_t             state_q, state_n, mode_state;
  logic [POS_W-1:0]   pos_q, pos_n;
  logic               dir_dn_q, dir_dn_n;
  logic               phase_q, phase_n;
  logic               wrap_n;
  logic [N_LED-1:0]   lit_n, led_n;

  logic [CNT_W-1:0]   period_q, remain_q, period_new;
  logic               step;

  // A load forces the new period to at least one cycle and restarts the count.
  assign period_new = (period_in == '0) ? CNT_W'(1) : period_in;
  assign step       = en && !period_ld && (remain_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= CNT_W'(STEP_CYCLES);
      remain_q <= CNT_W'(STEP_CYCLES - 1);
    end else if (period_ld) begin
      period_q <= period_new;
      remain_q <= period_new - CNT_W'(1);
    end else if (en) begin
      if (remain_q == '0) remain_q <= period_q - CNT_W'(1);
      else                remain_q <= remain_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BLANK;
      pos_q      <= '0;
      dir_dn_q   <= 1'b0;
      phase_q    <= 1'b0;
      led        <= LED_OFF;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state_q    <= state_n;
      pos_q      <= pos_n;
      dir_dn_q   <= dir_dn_n;
      phase_q    <= phase_n;
      led        <= led_n;
      step_pulse <= step;
      wrap       <= wrap_n;
    end
  end

  always_comb begin
    mode_state = S_UP;
    case (mode)
      2'd0:    mode_state = S_UP;
      2'd1:    mode_state = S_DOWN;
      2'd2:    mode_state = S_PING;
      default: mode_state = S_BLINK;
    endcase
  end

  // S_BLANK never equals a mode state, so the first step always restarts.
  always_comb begin
    state_n  = state_q;
    pos_n    = pos_q;
    dir_dn_n = dir_dn_q;
    phase_n  = phase_q;
    wrap_n   = 1'b0;
    if (step) begin
      if (state_q != mode_state) begin
        state_n  = mode_state;
        pos_n    = (mode == 2'd1) ? POS_LAST : '0;
        dir_dn_n = 1'b0;
        phase_n  = 1'b1;
      end else begin
        case (state_q)
          S_UP: begin
            if (pos_q == POS_LAST) begin
              pos_n  = '0;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos_q + POS_ONE;
            end
          end
          S_DOWN: begin
            if (pos_q == '0) begin
              pos_n  = POS_LAST;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos_q - POS_ONE;
            end
          end
          S_PING: begin
            if (!dir_dn_q) begin
              pos_n = pos_q + POS_ONE;
              if (pos_q + POS_ONE == POS_LAST) dir_dn_n = 1'b1;
            end else begin
              pos_n = pos_q - POS_ONE;
              if (pos_q == POS_ONE) begin
                dir_dn_n = 1'b0;
                wrap_n   = 1'b1;
              end
            end
          end
          S_BLINK: begin
            phase_n = !phase_q;
            wrap_n  = phase_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    lit_n = '0;
    case (state_n)
      S_BLANK: lit_n = '0;
      S_BLINK: lit_n = {N_LED{phase_n}};
      default: lit_n = N_LED'(1) << pos_n;
    endcase
    led_n = ACTIVE_LOW ? ~lit_n : lit_n;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized scoreboard bench for led_sequencer (N_LED=4, STEP_CYCLES=4, active-low LEDs).
// The model predicts each step from pattern tables; a monitor matches DUT steps against the queue.
module tb_led_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        period_ld = 1'b0;
  logic [31:0] period_in = '0;
  logic [3:0]  led;
  logic        step_pulse;
  logic        wrap;

  led_sequencer #(
    .N_LED(4), .CNT_W(32), .STEP_CYCLES(STEP), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .period_ld(period_ld), .period_in(period_in),
    .led(led), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // model state
  int         dcyc = 0;
  int         m_cnt, m_period, m_cur, m_idx;
  bit         m_blank;
  logic [3:0] m_led;

  function automatic int seq_len(int md);
    case (md)
      0, 1:    return 4;
      2:       return 6;
      default: return 2;
    endcase
  endfunction

  function automatic int wrap_idx(int md);
    return (md == 3) ? 1 : 0;
  endfunction

  function automatic logic [3:0] lit_of(int md, int idx);
    logic [3:0] one = 4'b0001;
    case (md)
      0:       return one << idx;
      1:       return one << (3 - idx);
      2:       return (idx < 4) ? (one << idx) : (one << (6 - idx));
      default: return (idx == 0) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit e, input int m, input bit ld, input int pin);
    bit st;
    bit w;
    dcyc++;
    if (r) begin
      m_cnt = 0; m_period = STEP; m_blank = 1; m_cur = 0; m_idx = 0; m_led = 4'hF;
    end else begin
      st = 0;
      w  = 0;
      if (ld) begin
        m_period = (pin < 1) ? 1 : pin;
        m_cnt = 0;
      end else if (e) begin
        if (m_cnt == m_period - 1) begin
          m_cnt = 0;
          st = 1;
        end else begin
          m_cnt++;
        end
      end
      if (st) begin
        if (m_blank || m != m_cur) begin
          m_blank = 0; m_cur = m; m_idx = 0;
        end else begin
          m_idx = (m_idx + 1) % seq_len(m_cur);
          w = (m_idx == wrap_idx(m_cur));
        end
        m_led = ~lit_of(m_cur, m_idx);
        q.push_back('{dcyc, m_led, w});
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input int m, input bit ld, input int pin);
    @(negedge clk);
    rst = r; en = e; mode = 2'(m); period_ld = ld; period_in = 32'(pin);
    @(posedge clk);
    model_step(r, e, m, ld, pin);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // monitor: per-cycle LED check plus scoreboard match on every step pulse
  initial begin
    int mcyc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      mcyc++;
      check("led_now", int'(led), int'(m_led));
      if (step_pulse === 1'b1) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_step actual=1 required=0 cycle=%0d", mcyc);
        end else begin
          e = q.pop_front();
          check("step_cycle", mcyc, e.cyc);
          check("step_led", int'(led), int'(e.led));
          check("step_wrap", int'(wrap), int'(e.wrap));
        end
      end else begin
        check("step_idle", int'(step_pulse), 0);
        check("wrap_idle", int'(wrap), 0);
        if (q.size() > 0 && q[0].cyc <= mcyc) begin
          checks++; failures++;
          $display("FAIL missed_step actual=0 required=1 cycle=%0d", q[0].cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int md;
    @(posedge clk);
    model_step(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // rotate-up from reset
    repeat (30) cycle(0, 1, 0, 0, 0);
    // ping-pong from reset
    cycle(1, 0, 2, 0, 0);
    repeat (40) cycle(0, 1, 2, 0, 0);
    // blink, then switch to rotate-down mid-period
    cycle(1, 0, 3, 0, 0);
    repeat (22) cycle(0, 1, 3, 0, 0);
    repeat (10) cycle(0, 1, 1, 0, 0);
    // load in a range of periods including 0 and 1
    for (int p = 0; p < 4; p++) begin
      cycle(0, 1, 1, 1, p);
      repeat (12) cycle(0, 1, 1, 0, 0);
    end
    // enable gating mid-period
    cycle(0, 1, 0, 1, 4);
    repeat (6) cycle(0, 1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0, 0);
    repeat (10) cycle(0, 1, 0, 0, 0);
    // randomized run
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, e, ld;
      int pin;
      if ($urandom_range(0, 39) == 0) md = int'($urandom_range(0, 3));
      r   = ($urandom_range(0, 249) == 0);
      e   = ($urandom_range(0, 7) != 0);
      ld  = ($urandom_range(0, 29) == 0);
      pin = int'($urandom_range(0, 6));
      cycle(r, e, md, ld, pin);
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
